// File: rtl/adder_share_scheduler.sv
// Round-robin scheduler that time-shares one external multicycle adder among
// NUM_REQ requesters and returns each sum through a single-entry response register.
module adder_share_scheduler #(
  parameter int WIDTH      = 22,
  parameter int NUM_REQ    = 4,
  parameter int ADD_CYCLES = 2,
  parameter int ID_W       = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  output logic [NUM_REQ-1:0]       o_req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_term1,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_term2,
  output logic [WIDTH-1:0]         o_add_term1,
  output logic [WIDTH-1:0]         o_add_term2,
  input  logic [WIDTH:0]           i_add_result,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [ID_W-1:0]          o_rsp_id,
  output logic [WIDTH:0]           o_rsp_result,
  output logic                     o_busy
);

  localparam int CNT_W = (ADD_CYCLES > 1) ? $clog2(ADD_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            r_state, w_next_state;
  logic [ID_W-1:0]   r_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [WIDTH-1:0]  r_term1, r_term2;
  logic [WIDTH:0]    r_result;
  logic [ID_W-1:0]   r_rsp_id;
  logic              r_rsp_valid;

  logic [ID_W-1:0]   w_cand [NUM_REQ];
  logic [ID_W-1:0]   w_grant_id;
  logic [ID_W-1:0]   w_next_ptr;
  logic              w_found;

  // Handshakes: a request transfers on the edge where i_req_valid[k] && o_req_ready[k];
  // a response transfers on the edge where o_rsp_valid && i_rsp_ready. Nothing else moves data.

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand[i] = ID_W'((int'(r_ptr) + i) % NUM_REQ);
    end
  end

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    w_found    = 1'b0;
    w_grant_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_req_valid[w_cand[i]]) begin
        w_found    = 1'b1;
        w_grant_id = w_cand[i];
      end
    end
  end

  assign w_next_ptr  = (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;
  assign o_req_ready = (!i_rst && r_state == S_IDLE && w_found) ?
                       (NUM_REQ'(1) << w_grant_id) : '0;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_found)       w_next_state = S_WAIT;
      S_WAIT:  if (r_cnt == '0)   w_next_state = S_RESP;
      S_RESP:  if (i_rsp_ready)   w_next_state = S_IDLE;
      default:                    w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_term1     <= '0;
      r_term2     <= '0;
      r_result    <= '0;
      r_rsp_id    <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_term1  <= i_req_term1[w_grant_id*WIDTH +: WIDTH];
            r_term2  <= i_req_term2[w_grant_id*WIDTH +: WIDTH];
            r_rsp_id <= w_grant_id;
            r_cnt    <= CNT_W'(ADD_CYCLES - 1);
            r_ptr    <= w_next_ptr;
          end
        end
        S_WAIT: begin
          // Operands stay frozen so the ripple path settles before capture.
          if (r_cnt == '0) begin
            r_result    <= i_add_result;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: r_rsp_valid <= 1'b0;
      endcase
    end
  end

  assign o_add_term1  = r_term1;
  assign o_add_term2  = r_term2;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_id     = r_rsp_id;
  assign o_rsp_result = r_result;
  assign o_busy       = (r_state != S_IDLE);

endmodule
